// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO whose storage is an external synchronous SRAM;
// a 3-entry output queue hides the one-cycle read latency. Optional: SRAM_FIFO_BYPASS_EN.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + 2;

  // Streams: a word transfers on a rising edge where valid & ready are both high;
  // the sender keeps valid and data stable until that edge.

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         mem_count;
  logic [CW-1:0]         mem_count_nxt;
  logic                  rd_vld;

  logic [DATA_WIDTH-1:0] ob_mem [3];
  logic [1:0]            ob_head;
  logic [1:0]            ob_count;
  logic [1:0]            ob_tail;
  logic [2:0]            tail_sum;
  logic [2:0]            ob_pending;

  logic s_fire;
  logic pop;
  logic rd_issue;
  logic ob_room;
  logic mem_nonempty;

  assign s_fire       = s_valid & s_ready;
  assign m_valid      = (ob_count != 2'd0);
  assign pop          = m_valid & m_ready;
  assign mem_nonempty = (mem_count != '0);

  // Words already queued plus the one in flight must leave room for another read.
  assign ob_pending = {1'b0, ob_count} + {2'b00, rd_vld};
  assign ob_room    = (ob_pending < 3'd3);

`ifdef SRAM_FIFO_BYPASS_EN
  // Empty SRAM: read the address being written so the write-through data
  // comes straight back next cycle.
  assign rd_issue = ob_room & (mem_nonempty | s_fire);
`else
  assign rd_issue = ob_room & mem_nonempty;
`endif

  assign mem_cs     = s_fire | rd_issue;
  assign mem_we     = s_fire;
  assign mem_w_addr = wr_ptr;
  assign mem_r_addr = rd_ptr;
  assign mem_din    = s_data;

  assign mem_count_nxt = mem_count + CW'(s_fire) - CW'(rd_issue);

  // Output queue is a 3-slot ring; the tail is head + count modulo 3.
  assign tail_sum = {1'b0, ob_head} + {1'b0, ob_count};
  assign ob_tail  = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];

  assign m_data = ob_mem[ob_head];
  assign level  = LW'(mem_count) + LW'(rd_vld) + LW'(ob_count);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_vld    <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      if (s_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_vld    <= rd_issue;
      mem_count <= mem_count_nxt;
      s_ready   <= (mem_count_nxt < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) ob_mem[i] <= '0;
      ob_head  <= 2'd0;
      ob_count <= 2'd0;
    end else begin
      if (rd_vld) ob_mem[ob_tail] <= mem_dout;
      if (pop) ob_head <= (ob_head == 2'd2) ? 2'd0 : ob_head + 2'd1;
      ob_count <= ob_count + 2'(rd_vld) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM model, randomized traffic, queue scoreboard.
module tb_sram_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 3;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_w_addr;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model (write-through on same-address read) ----------------
  logic [DW-1:0] sram [DEPTH];
  initial mem_dout = '0;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_w_addr] <= mem_din;
      mem_dout <= (mem_we && mem_r_addr == mem_w_addr) ? mem_din : sram[mem_r_addr];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  int            acc_cnt = 0;
  int            pop_cnt = 0;
  int            wr_model = 0;
  int            cyc = 0;
  bit            mon_on = 0;
  bit            last_fire = 0;
  bit            hold_prev = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] last_pop_data = '0;
  bit            stream_mode = 0;
  int            stream_pops = 0;
  int            stream_gaps = 0;
  int            last_pop_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on && rstn) begin
      check_eq("level", 32'(level), exp_q.size());
      if (level < DEPTH) check_eq("s_ready_room", 32'(s_ready), 1);
      if (level == CAP) check_eq("s_ready_full", 32'(s_ready), 0);
      check_eq("level_max", 32'(level <= CAP), 1);
      if (hold_prev) begin
        check_eq("bp_valid", 32'(m_valid), 1);
        check_eq("bp_data", 32'(m_data), 32'(prev_data));
      end
      check_eq("mem_we", 32'(mem_we), 32'(s_valid & s_ready));
      if (s_valid && s_ready) check_eq("mem_din", 32'(mem_din), 32'(s_data));
      check_eq("w_addr", 32'(mem_w_addr), wr_model % DEPTH);
      if (mem_cs && !mem_we) check_eq("rd_nonempty", 32'(level != 0), 1);
      if (!(s_valid && s_ready) && level == 0) check_eq("cs_idle", 32'(mem_cs), 0);
      if (m_valid && m_ready) begin
        check_eq("pop_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("data", 32'(m_data), 32'(exp_q.pop_front()));
        if (stream_mode) begin
          if (stream_pops > 0 && cyc != last_pop_cyc + 1) stream_gaps++;
          stream_pops++;
        end
        last_pop_cyc  = cyc;
        last_pop_data = m_data;
        pop_cnt++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        acc_cnt++;
        wr_model++;
      end
      last_fire = s_valid & s_ready;
      hold_prev = m_valid & !m_ready;
      prev_data = m_data;
    end else begin
      last_fire = 0;
      hold_prev = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check_eq("rst_s_ready", 32'(s_ready), 0);
    check_eq("rst_m_valid", 32'(m_valid), 0);
    check_eq("rst_m_data", 32'(m_data), 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_mem_cs", 32'(mem_cs), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_w_addr", 32'(mem_w_addr), 0);
    check_eq("rst_r_addr", 32'(mem_r_addr), 0);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (level == 0 && exp_q.size() == 0) done = 1;
    end
    check_eq(tag, 32'(level), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("rel_s_ready_low", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    check_eq("rel_s_ready_high", 32'(s_ready), 1);
    check_eq("rel_m_valid", 32'(m_valid), 0);
    mon_on = 1;
  endtask

  task automatic single_word();
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hA5A5;
    check_eq("sw_ready", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check_eq("sw_valid", 32'(m_valid), 32'(k == LAT - 1));
      if (k == LAT - 1) check_eq("sw_data", 32'(m_data), 32'h0000A5A5);
    end
    @(negedge clk);
    check_eq("sw_level_after", 32'(level), 0);
    check_eq("sw_valid_after", 32'(m_valid), 0);
  endtask

  task automatic fill_test();
    int acc0 = acc_cnt;
    int pop0 = pop_cnt;
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(acc_cnt - acc0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("fill_accepted", acc_cnt - acc0, CAP);
    check_eq("fill_level", 32'(level), CAP);
    check_eq("fill_s_ready", 32'(s_ready), 0);
    check_eq("fill_m_valid", 32'(m_valid), 1);
    check_eq("fill_m_data", 32'(m_data), 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain("fill_drain", 200);
    check_eq("fill_pops", pop_cnt - pop0, CAP);
  endtask

  task automatic stream_test();
    int acc0 = acc_cnt;
    bit done = 0;
    stream_pops = 0;
    stream_gaps = 0;
    stream_mode = 1;
    m_ready     = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (acc_cnt - acc0 >= 40) begin
        s_valid = 1'b0;
        done = 1;
      end else begin
        s_valid = 1'b1;
        s_data  = 16'(acc_cnt - acc0);
      end
    end
    wait_drain("stream_drain", 200);
    stream_mode = 0;
    check_eq("stream_pops", stream_pops, 40);
    check_eq("stream_gaps", stream_gaps, 0);
  endtask

  task automatic random_test(input int n_words);
    int  acc0 = acc_cnt;
    bit  cur_valid = 0;
    for (int i = 0; i < 20000 && (cur_valid || acc_cnt - acc0 < n_words); i++) begin
      @(posedge clk); #1;
      if (last_fire) cur_valid = 0;
      if (!cur_valid && acc_cnt - acc0 < n_words && $urandom_range(0, 99) < 70) begin
        cur_valid = 1;
        s_data    = 16'($urandom);
      end
      s_valid = cur_valid;
      m_ready = ($urandom_range(0, 99) < 60);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_drain("rand_drain", 500);
    check_eq("rand_count", acc_cnt - acc0, n_words);
  endtask

  task automatic mid_reset_test();
    int  pop0;
    bit  done = 0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (level >= 10) done = 1;
      else if (last_fire) s_data = 16'($urandom);
    end
    check_eq("pre_rst_level", 32'(level), 10);
    mon_on  = 0;
    s_valid = 1'b0;
    rstn    = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    wr_model = 0;
    repeat (2) @(posedge clk);
    release_reset();
    pop0 = pop_cnt;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h1234;
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_drain("post_rst_drain", 50);
    check_eq("post_rst_pops", pop_cnt - pop0, 1);
    check_eq("post_rst_data", 32'(last_pop_data), 32'h00001234);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    release_reset();
    single_word();
    fill_test();
    stream_test();
    random_test(1000);
    mid_reset_test();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Streaming FIFO controller that drives a single-port-pair synchronous SRAM as its storage array. It presents valid/ready streams upstream and downstream and generates the SRAM's chip-select, write-enable, read/write addresses and write data. It absorbs the SRAM's one-cycle read latency with a 3-entry output queue. It sits between a producer stage and a consumer stage wherever a buffer deeper than a register file is needed.

## Interface
- DATA_WIDTH, 16, word width; must match the attached SRAM.
- ADDR_WIDTH, 4, SRAM address width; SRAM depth DEPTH = 2^ADDR_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready; registered.
- s_data  in  DATA_WIDTH  upstream word.
- m_valid  out  1  downstream word valid; this is output-queue non-empty.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  downstream word; this is the output-queue head.
- level  out  ADDR_WIDTH+2  total words held: mem_count + rd_vld + ob_count.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_w_addr  out  ADDR_WIDTH  SRAM write address, equal to wr_ptr.
- mem_r_addr  out  ADDR_WIDTH  SRAM read address, equal to rd_ptr.
- mem_din  out  DATA_WIDTH  SRAM write data, equal to s_data.
- mem_dout  in  DATA_WIDTH  SRAM read data; valid in the cycle after a read issue.

## Operation
- State:
  - wr_ptr and rd_ptr, ADDR_WIDTH bits each; both wrap modulo DEPTH.
  - mem_count, ADDR_WIDTH+1 bits, range 0..DEPTH.
  - rd_vld, 1 bit; it marks that a read is in flight.
  - Output queue of 3 entries, with ob_count in the range 0..3.
- Definitions:
  - s_fire = s_valid & s_ready.
  - pop = m_valid & m_ready.
- Read issue: rd_issue = (mem_count != 0) & (ob_count + rd_vld < 3). m_ready has no combinational path to any mem_* output.
- Memory drive:
  - mem_cs = s_fire | rd_issue.
  - mem_we = s_fire.
- On s_fire: the SRAM writes at wr_ptr, and wr_ptr increments.
- On rd_issue: rd_ptr increments, and rd_vld is set for the next cycle.
- When rd_vld = 1: mem_dout is pushed into the output queue tail at the edge.
- mem_count next value = mem_count + s_fire − rd_issue.
- s_ready next value = (mem_count next value < DEPTH).
- Total capacity is DEPTH + 3 words. Order is strictly preserved.
- Simultaneous push and pop on the output queue in the same cycle: ob_count is unchanged and the head advances.
- Backpressure: while m_valid & !m_ready, m_data and m_valid hold stable.
- Full: s_ready = 0 when mem_count = DEPTH. Reads continue to drain the SRAM, and s_ready reasserts the cycle after mem_count drops below DEPTH.
- Empty: mem_count = 0, so no read is issued. m_valid is 0 once the queue has drained.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap. While mem_count ≠ 0, rd_ptr = wr_ptr only when the FIFO is full. In that state no write occurs, so the SRAM read-during-write path is never exercised, except by the configured bypass.

## Timing
- Reset (rstn low), regardless of activity:
  - Pointers, mem_count, rd_vld and ob_count are cleared to 0.
  - s_ready = 0, m_valid = 0, m_data = 0, level = 0.
  - mem_cs = mem_we = 0, and both addresses are 0.
  - All in-flight data is discarded.
- s_ready rises at the first clk edge after rstn deasserts.
- Latency from the cycle of s_fire into an empty FIFO to m_valid high is 3 cycles:
  - the write commits at edge E0;
  - the read issues in cycle 1;
  - mem_dout is valid in cycle 2;
  - the output queue holds the word from cycle 3.
- Throughput is 1 word/cycle sustained when s_valid = m_ready = 1.
- level reflects state after each edge. It does not count the current-cycle s_fire.

## Configuration
- SRAM_FIFO_BYPASS_EN defined:
  - If mem_count = 0, s_fire = 1 and ob_count + rd_vld < 3, rd_issue is also asserted in the same cycle, with mem_r_addr = mem_w_addr.
  - The SRAM write-through returns s_data on mem_dout in the next cycle.
  - Both pointers advance, and mem_count stays 0.
  - Empty-to-m_valid latency becomes 2 cycles.
- Not defined: no read is issued to an uncommitted entry, and latency is 3 cycles. All other behaviour is identical.

## Test plan
- Reset values: hold rstn low for 3 cycles, release with s_valid = 0.
  - All outputs are 0 during reset.
  - s_ready = 1 from the first edge after release.
  - m_valid stays 0.
- Single word: push 0xA5A5 into an empty FIFO with m_ready = 1.
  - m_valid rises 3 cycles after the s_fire cycle (2 with SRAM_FIFO_BYPASS_EN), with m_data = 0xA5A5.
  - level returns to 0 after the pop.
- Fill: with m_ready = 0, ADDR_WIDTH = 4, push the incrementing words 0,1,2,…
  - Exactly 19 words are accepted; s_ready = 0 and level = 19.
  - m_data = 0 stays stable.
  - Raising m_ready then pops 0..18 in order.
- Streaming wrap: s_valid = m_ready = 1 continuously for 40 words.
  - One pop per cycle after the initial latency.
  - Output order is 0..39, across two pointer wraps.
- Random backpressure: random s_valid and m_ready, 1000 words.
  - The scoreboard matches order and count.
  - m_data is stable whenever m_valid & !m_ready.
  - mem_cs never asserts with mem_count = 0, except for a bypass issue.
- Reset mid-operation: assert rstn with level = 10.
  - All state clears immediately, and level = 0.
  - After release, a new word 0x1234 emerges first and alone.
